// File: rtl/spimem_porta_sched.sv
// Port-A scheduler for the dual-port spimem buffer: fills memory after reset, then round-robins host writes/reads.
// Optional macro SPIMEM_REFILL_EN adds a refill input that re-runs the fill from the arbitration state.
module spimem_porta_sched #(
  parameter int               ADDR_W       = 10,
  parameter int               DATA_W       = 32,
  parameter logic [DATA_W-1:0] FILL_PATTERN = 32'h5A6C_C6A5,
  parameter int               RD_LATENCY   = 1
) (
  input  logic              SysClk,
  input  logic              Reset,
`ifdef SPIMEM_REFILL_EN
  input  logic              refill,
`endif
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              init_done,
  output logic              busy
);

  localparam int WCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {S_FILL, S_ARB, S_RD_WAIT} state_t;
  typedef enum logic {G_WRITE, G_READ} grant_t;

  state_t          state;
  grant_t          last_grant;
  logic [ADDR_W:0] fill_cnt;
  logic [WCW-1:0]  wait_cnt;

  // A requester acked this cycle is still holding req; mask it so it is not served twice.
  logic wr_elig, rd_elig, grant_wr, grant_rd, refill_go;
  assign wr_elig  = wr_req & ~wr_ack;
  assign rd_elig  = rd_req & ~rd_ack;
  assign grant_wr = wr_elig & (~rd_elig | (last_grant == G_READ));
  assign grant_rd = rd_elig & ~grant_wr;

`ifdef SPIMEM_REFILL_EN
  logic refill_pend;
  assign refill_go = refill | refill_pend;
`else
  assign refill_go = 1'b0;
`endif

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state      <= S_FILL;
      last_grant <= G_READ;
      fill_cnt   <= '0;
      wait_cnt   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= FILL_PATTERN;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b1;
`ifdef SPIMEM_REFILL_EN
      refill_pend <= 1'b0;
`endif
    end else begin
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        S_FILL: begin
          // fill_cnt MSB set means the last word went out on the previous edge.
          if (!fill_cnt[ADDR_W]) begin
            mem_we   <= 1'b1;
            mem_addr <= fill_cnt[ADDR_W-1:0];
            mem_din  <= FILL_PATTERN;
            fill_cnt <= fill_cnt + (ADDR_W+1)'(1);
            busy     <= 1'b1;
          end else begin
            init_done <= 1'b1;
            busy      <= 1'b0;
            state     <= S_ARB;
          end
        end
        S_ARB: begin
          if (refill_go) begin
            state     <= S_FILL;
            fill_cnt  <= '0;
            init_done <= 1'b0;
            busy      <= 1'b1;
`ifdef SPIMEM_REFILL_EN
            refill_pend <= 1'b0;
`endif
          end else if (grant_wr) begin
            mem_we     <= 1'b1;
            mem_addr   <= wr_addr;
            mem_din    <= wr_data;
            wr_ack     <= 1'b1;
            last_grant <= G_WRITE;
            busy       <= 1'b1;
          end else if (grant_rd) begin
            mem_addr   <= rd_addr;
            rd_ack     <= 1'b1;
            last_grant <= G_READ;
            wait_cnt   <= WCW'(RD_LATENCY - 1);
            state      <= S_RD_WAIT;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_RD_WAIT: begin
`ifdef SPIMEM_REFILL_EN
          refill_pend <= refill_pend | refill;
`endif
          if (wait_cnt == '0) begin
            rd_data  <= mem_dout;
            rd_valid <= 1'b1;
            state    <= S_ARB;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - WCW'(1);
            busy     <= 1'b1;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_spimem_porta_sched.sv
// Scoreboard bench for spimem_porta_sched: expected memory writes and read data are queued by the stimulus
// and popped by a negedge monitor; the memory itself is a small behavioural model.
module tb_spimem_porta_sched;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [31:0] FP = 32'h5A6C_C6A5;

  logic          SysClk = 1'b0;
  logic          Reset  = 1'b1;
`ifdef SPIMEM_REFILL_EN
  logic          refill = 1'b0;
`endif
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack, rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          init_done, busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [AW+DW-1:0] wq[$];
  logic [DW-1:0]    rq[$];

  always #5 SysClk = ~SysClk;

  spimem_porta_sched dut (
    .SysClk(SysClk), .Reset(Reset),
`ifdef SPIMEM_REFILL_EN
    .refill(refill),
`endif
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .init_done(init_done), .busy(busy)
  );

  // Port-A model: data for the registered address is readable within the same cycle.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  always @(posedge SysClk) if (mem_we) mem_model[mem_addr] <= mem_din;
  assign mem_dout = mem_model[mem_addr];

  logic prev_wr_ack = 1'b0, prev_rd_ack = 1'b0, prev_wr_req = 1'b0, prev_rd_req = 1'b0;

  always @(negedge SysClk) begin
    logic [AW+DW-1:0] we_exp;
    logic [DW-1:0]    rd_exp;
    if (Reset) begin
      prev_wr_ack <= 1'b0; prev_rd_ack <= 1'b0; prev_wr_req <= 1'b0; prev_rd_req <= 1'b0;
    end else begin
      if (mem_we) begin
        we_cnt++;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h din=%h (no write expected)", mem_addr, mem_din);
        end else begin
          we_exp = wq.pop_front();
          if ({mem_addr, mem_din} !== we_exp) begin
            errors++;
            $display("FAIL mem_write got addr=%h din=%h expected addr=%h din=%h",
                     mem_addr, mem_din, we_exp[AW+DW-1:DW], we_exp[DW-1:0]);
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid rd_data=%h (no read expected)", rd_data);
        end else begin
          rd_exp = rq.pop_front();
          if (rd_data !== rd_exp) begin
            errors++;
            $display("FAIL rd_data got %h expected %h", rd_data, rd_exp);
          end
        end
        if (!prev_rd_ack) begin
          errors++;
          $display("FAIL rd_valid_timing got rd_valid=1 without rd_ack one cycle earlier");
        end
      end
      if (prev_rd_ack) begin
        checks++;
        if (rd_valid !== 1'b1) begin
          errors++;
          $display("FAIL rd_valid_latency got %b expected 1 one cycle after rd_ack", rd_valid);
        end
      end
      if (rd_ack) begin
        checks++;
        if (mem_we !== 1'b0 || prev_rd_ack || !init_done) begin
          errors++;
          $display("FAIL rd_ack_cycle got mem_we=%b prev_rd_ack=%b init_done=%b expected 0,0,1",
                   mem_we, prev_rd_ack, init_done);
        end
      end
      if (wr_ack) begin
        checks++;
        if (mem_we !== 1'b1 || prev_wr_ack || !init_done) begin
          errors++;
          $display("FAIL wr_ack_cycle got mem_we=%b prev_wr_ack=%b init_done=%b expected 1,0,1",
                   mem_we, prev_wr_ack, init_done);
        end
      end
      if ((prev_wr_req && !wr_req && !wr_ack && !prev_wr_ack) ||
          (prev_rd_req && !rd_req && !rd_ack && !prev_rd_ack)) begin
        errors++;
        $display("FAIL req_protocol got request dropped before its ack");
      end
      prev_wr_ack <= wr_ack; prev_rd_ack <= rd_ack;
      prev_wr_req <= wr_req; prev_rd_req <= rd_req;
    end
  end

  task automatic step();
    @(posedge SysClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_fill();
    for (int i = 0; i < (1 << AW); i++) wq.push_back({AW'(i), FP});
  endtask

  // Counts edges from the current point until init_done rises.
  task automatic fill_check(input string tag);
    int n = 0;
    int we0 = we_cnt;
    while (1) begin
      step();
      n++;
      if (init_done || n > 1200) break;
    end
    check({tag, "_cycles"}, 64'(n), 64'd1025);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    check({tag, "_write_count"}, 64'(we_cnt - we0), 64'd1024);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wq.push_back({a, d});
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    while (n < 20) begin
      step(); n++;
      if (wr_ack) break;
    end
    check("write_ack_seen", 64'(wr_ack), 64'd1);
    wr_req = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int n = 0;
    rq.push_back(exp);
    rd_req = 1'b1; rd_addr = a;
    while (n < 20) begin
      step(); n++;
      if (rd_ack) break;
    end
    check("read_ack_seen", 64'(rd_ack), 64'd1);
    rd_req = 1'b0;
    step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int wn, rn, n;

    repeat (3) step();
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_mem_din", 64'(mem_din), 64'(FP));
    check("rst_acks", 64'({wr_ack, rd_ack, rd_valid, mem_addr}), 64'd0);

    // Initial fill with a write raised at fill cycle 10; it must wait for the first ARB edge.
    push_fill();
    wq.push_back({10'h005, 32'hDEAD_BEEF});
    Reset = 1'b0;
    fork
      fill_check("fill1");
      begin
        repeat (10) step();
        wr_req = 1'b1; wr_addr = 10'h005; wr_data = 32'hDEAD_BEEF;
      end
    join
    step();
    check("first_arb_write", 64'({wr_ack, mem_we, mem_addr}), 64'({1'b1, 1'b1, 10'h005}));
    wr_req = 1'b0;
    step();

    do_read(10'h005, 32'hDEAD_BEEF);
    do_read(10'h006, FP);
    do_write(10'h3FF, 32'h0123_4567);
    do_read(10'h3FF, 32'h0123_4567);

    // Both held; last grant was a read so write goes first.
    wq.push_back({10'd20, 32'h1111_1111});
    wq.push_back({10'd20, 32'h1111_1111});
    rq.push_back(32'h1111_1111);
    rq.push_back(32'h1111_1111);
    wr_req = 1'b1; wr_addr = 10'd20; wr_data = 32'h1111_1111;
    rd_req = 1'b1; rd_addr = 10'd20;
    wn = 0; rn = 0; n = 0;
    while (n < 40 && (wn < 2 || rn < 2)) begin
      step(); n++;
      if (wr_ack) begin order.push_back(1); wn++; if (wn == 2) wr_req = 1'b0; end
      if (rd_ack) begin order.push_back(2); rn++; if (rn == 2) rd_req = 1'b0; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("rr_grant_count", 64'(order.size()), 64'd4);
    if (order.size() == 4)
      check("rr_order", 64'({order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}), 64'h1212);
    repeat (4) step();

    // Reset mid-fill after 300 words; outputs must clear without waiting for an edge.
    wq.delete();
    push_fill();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    repeat (300) step();
    check("midfill_we_before", 64'(mem_we), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_outputs", 64'({mem_we, init_done, busy, mem_addr}), 64'({1'b0, 1'b0, 1'b1, 10'd0}));
    check("async_rst_din", 64'(mem_din), 64'(FP));
    wq.delete();
    push_fill();
    step();
    Reset = 1'b0;
    fill_check("fill2");
    step();

`ifdef SPIMEM_REFILL_EN
    push_fill();
    wq.push_back({10'h007, 32'hCAFE_F00D});
    refill = 1'b1;
    wr_req = 1'b1; wr_addr = 10'h007; wr_data = 32'hCAFE_F00D;
    step();
    check("refill_drop_init", 64'({init_done, wr_ack}), 64'd0);
    refill = 1'b0;
    fill_check("refill");
    n = 0;
    while (n < 5) begin
      step(); n++;
      if (wr_ack) break;
    end
    check("refill_write_after_init", 64'({wr_ack, init_done, 3'(n)}), 64'({1'b1, 1'b1, 3'd1}));
    wr_req = 1'b0;
    step();
`endif

    repeat (5) step();
    check("write_queue_drained", 64'(wq.size()), 64'd0);
    check("read_queue_drained", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
